// File: rtl/alu_iter_ctrl.sv
// Multi-cycle sequencer that borrows the shared combinational ALU one cycle at a time
// to run normalize, divide-by-subtraction and 4-bit pattern count commands.
module alu_iter_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] CMD,
    input  logic [7:0] OPA,
    input  logic [7:0] OPB,
    input  logic [7:0] OPC,
    input  logic [3:0] PAT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] RESULT,
    output logic [7:0] COUNT,
    output logic       ALU_REQ,
    input  logic       ALU_GNT,
    output logic [2:0] ALU_OP,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic       ALU_CI,
    input  logic [7:0] ALU_OUT,
    input  logic       ALU_CO
);

    localparam logic [2:0] kADD = 3'd0;
    localparam logic [2:0] kSUB = 3'd1;
    localparam logic [2:0] kSLL = 3'd4;

    localparam logic [1:0] CmdNorm = 2'd0;
    localparam logic [1:0] CmdDiv  = 2'd1;
    localparam logic [1:0] CmdPat  = 2'd2;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  r_q, r_d;        // working value: NORM shifter / DIV remainder
    logic [7:0]  d_q, d_d;        // divisor
    logic [15:0] w_q, w_d;        // pattern window, shifted right one bit per offset
    logic [3:0]  pat_q, pat_d;
    logic [7:0]  n_q, n_d;        // shift count / quotient / match count
    logic [3:0]  k_q, k_d;        // pattern offset
    logic        found_q, found_d;
    logic [7:0]  first_q, first_d;
    logic [7:0]  result_q, result_d;
    logic [7:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        match;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            cmd_q    <= 2'd0;
            r_q      <= 8'd0;
            d_q      <= 8'd0;
            w_q      <= 16'd0;
            pat_q    <= 4'd0;
            n_q      <= 8'd0;
            k_q      <= 4'd0;
            found_q  <= 1'b0;
            first_q  <= 8'd0;
            result_q <= 8'd0;
            count_q  <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            r_q      <= r_d;
            d_q      <= d_d;
            w_q      <= w_d;
            pat_q    <= pat_d;
            n_q      <= n_d;
            k_q      <= k_d;
            found_q  <= found_d;
            first_q  <= first_d;
            result_q <= result_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign match = (w_q[3:0] == pat_q);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        r_d      = r_q;
        d_d      = d_q;
        w_d      = w_q;
        pat_d    = pat_q;
        n_d      = n_q;
        k_d      = k_q;
        found_d  = found_q;
        first_d  = first_q;
        result_d = result_q;
        count_d  = count_q;
        err_d    = err_q;
        ALU_REQ  = 1'b0;
        ALU_OP   = kADD;
        ALU_A    = 8'd0;
        ALU_B    = 8'd0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    cmd_d    = CMD;
                    r_d      = OPA;
                    d_d      = OPC;
                    w_d      = {OPA, OPB};
                    pat_d    = PAT;
                    n_d      = 8'd0;
                    k_d      = 4'd0;
                    found_d  = 1'b0;
                    first_d  = 8'd0;
                    result_d = 8'd0;
                    count_d  = 8'd0;
                    err_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                case (cmd_q)
                    CmdNorm: begin
                        ALU_REQ = 1'b1;
                        ALU_OP  = kSLL;
                        ALU_A   = r_q;
                        if (ALU_GNT) begin
                            if (r_q == 8'd0) begin
                                result_d = 8'd0;
                                count_d  = 8'd0;
                                err_d    = 1'b1;
                                state_d  = StFin;
                            end else if (r_q[7]) begin
                                result_d = r_q;
                                count_d  = n_q;
                                state_d  = StFin;
                            end else begin
                                r_d = ALU_OUT;
                                n_d = n_q + 8'd1;
                            end
                        end
                    end
                    CmdDiv: begin
                        if (d_q == 8'd0) begin
                            result_d = 8'hFF;
                            count_d  = r_q;
                            err_d    = 1'b1;
                            state_d  = StFin;
                        end else begin
                            ALU_REQ = 1'b1;
                            ALU_OP  = kSUB;
                            ALU_A   = r_q;
                            ALU_B   = d_q;
                            if (ALU_GNT) begin
                                if (!ALU_CO) begin
                                    r_d = ALU_OUT;
                                    n_d = n_q + 8'd1;
                                end else begin
                                    result_d = n_q;
                                    count_d  = r_q;
                                    state_d  = StFin;
                                end
                            end
                        end
                    end
                    CmdPat: begin
                        n_d = n_q + {7'd0, match};
                        if (match && !found_q) begin
                            found_d = 1'b1;
                            first_d = {4'd0, k_q};
                        end
                        w_d = {1'b0, w_q[15:1]};
                        k_d = k_q + 4'd1;
                        if (k_q == 4'd12) begin
                            count_d = n_q + {7'd0, match};
                            if (found_q)    result_d = first_q;
                            else if (match) result_d = {4'd0, k_q};
                            else            result_d = 8'hFF;
                            state_d = StFin;
                        end
                    end
                    default: begin
                        result_d = 8'd0;
                        count_d  = 8'd0;
                        err_d    = 1'b1;
                        state_d  = StFin;
                    end
                endcase
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign BUSY   = (state_q != StIdle);
    assign DONE   = (state_q == StFin);
    assign ERR    = err_q;
    assign RESULT = result_q;
    assign COUNT  = count_q;
    assign ALU_CI = 1'b0;

endmodule

// File: tb/tb_alu_iter_ctrl.sv
// Directed bench for alu_iter_ctrl: behavioural ALU, reference model feeding a scoreboard queue.
module tb_alu_iter_ctrl;

    localparam logic [2:0] kADD = 3'd0;
    localparam logic [2:0] kSUB = 3'd1;
    localparam logic [2:0] kSLL = 3'd4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] CMD = 2'd0;
    logic [7:0] OPA = 8'd0, OPB = 8'd0, OPC = 8'd0;
    logic [3:0] PAT = 4'd0;
    logic       BUSY, DONE, ERR, ALU_REQ, ALU_CI, ALU_CO;
    logic [7:0] RESULT, COUNT, ALU_A, ALU_B, ALU_OUT;
    logic [2:0] ALU_OP;
    logic       ALU_GNT = 1'b1;

    int total = 0;
    int bad = 0;
    bit last_req;

    typedef struct {
        logic [7:0] result;
        logic [7:0] count;
        logic       err;
        int         cycles;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    alu_iter_ctrl dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CMD(CMD),
        .OPA(OPA), .OPB(OPB), .OPC(OPC), .PAT(PAT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT), .COUNT(COUNT),
        .ALU_REQ(ALU_REQ), .ALU_GNT(ALU_GNT), .ALU_OP(ALU_OP),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CI(ALU_CI),
        .ALU_OUT(ALU_OUT), .ALU_CO(ALU_CO)
    );

    // Shared ALU stand-in; CO is the borrow for SUB.
    always_comb begin
        ALU_OUT = 8'd0;
        ALU_CO  = 1'b0;
        case (ALU_OP)
            kADD: {ALU_CO, ALU_OUT} = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CI};
            kSUB: begin ALU_OUT = ALU_A - ALU_B; ALU_CO = (ALU_A < ALU_B); end
            kSLL: begin ALU_OUT = {ALU_A[6:0], 1'b0}; ALU_CO = ALU_A[7]; end
            default: ALU_OUT = 8'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // DONE cycle index counted from cycle 1 = first RUN cycle.
    function automatic exp_t model(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, input logic [3:0] p);
        exp_t e;
        logic [7:0] v;
        logic [15:0] w;
        int n;
        e.result = 8'd0; e.count = 8'd0; e.err = 1'b0; e.cycles = 2;
        case (cmd)
            2'd0: begin
                if (a == 8'd0) begin
                    e.err = 1'b1;
                end else begin
                    v = a; n = 0;
                    while (!v[7]) begin v = v << 1; n++; end
                    e.result = v; e.count = 8'(n); e.cycles = n + 2;
                end
            end
            2'd1: begin
                if (c == 8'd0) begin
                    e.result = 8'hFF; e.count = a; e.err = 1'b1;
                end else begin
                    e.result = a / c; e.count = a % c; e.cycles = int'(a / c) + 2;
                end
            end
            2'd2: begin
                w = {a, b}; n = 0; e.result = 8'hFF; e.cycles = 14;
                for (int k = 12; k >= 0; k--) begin
                    if (((w >> k) & 16'hF) == {12'd0, p}) begin n++; e.result = 8'(k); end
                end
                e.count = 8'(n);
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [3:0] p,
                          input int s0, input int sn, input bit poke, input string tag);
        exp_t e;
        int cyc;
        bit got;
        e = model(cmd, a, b, c, p);
        e.cycles += sn;
        exp_q.push_back(e);
        @(negedge CLK);
        CMD = cmd; OPA = a; OPB = b; OPC = c; PAT = p; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        cyc = 1; got = 1'b0; last_req = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            ALU_GNT = !(sn > 0 && cyc >= s0 && cyc < s0 + sn);
            if (poke) START = (cyc == 3);
            if (ALU_REQ) last_req = 1'b1;
            if (DONE) got = 1'b1;
            else begin
                @(posedge CLK);
                #1 cyc++;
            end
        end
        START = 1'b0;
        ALU_GNT = 1'b1;
        e = exp_q.pop_front();
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_result"}, 32'(RESULT), 32'(e.result));
            check({tag, "_count"}, 32'(COUNT), 32'(e.count));
            check({tag, "_err"}, 32'(ERR), 32'(e.err));
            check({tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
            @(negedge CLK);
            check({tag, "_idle_after"}, {30'd0, BUSY, DONE}, 32'd0);
            check({tag, "_held"}, {15'd0, ERR, RESULT, COUNT}, {15'd0, e.err, e.result, e.count});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {28'd0, BUSY, DONE, ERR, ALU_REQ}, 32'd0);
        check({tag, "_res_cnt"}, {16'd0, RESULT, COUNT}, 32'd0);
        check({tag, "_alu"}, {12'd0, ALU_OP, ALU_A, ALU_B, ALU_CI}, {12'd0, kADD, 17'd0});
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
        @(negedge CLK);

        run_op(2'd0, 8'h01, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, "norm_01");
        check("norm_01_req", 32'(last_req), 32'd1);
        run_op(2'd0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, "norm_00");
        run_op(2'd0, 8'h80, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, "norm_80");
        run_op(2'd0, 8'h13, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, "norm_13");
        run_op(2'd1, 8'd100, 8'h00, 8'd7, 4'h0, 0, 0, 1'b0, "div_100_7");
        run_op(2'd1, 8'd42, 8'h00, 8'd0, 4'h0, 0, 0, 1'b0, "div_by0");
        check("div_by0_noreq", 32'(last_req), 32'd0);
        run_op(2'd1, 8'd255, 8'h00, 8'd1, 4'h0, 0, 0, 1'b0, "div_255_1");
        run_op(2'd1, 8'd3, 8'h00, 8'd9, 4'h0, 0, 0, 1'b0, "div_3_9");
        run_op(2'd2, 8'hAA, 8'hAA, 8'h00, 4'hA, 0, 0, 1'b0, "pat_a");
        run_op(2'd2, 8'hAA, 8'hAA, 8'h00, 4'hF, 0, 0, 1'b0, "pat_f");
        run_op(2'd2, 8'hF0, 8'h00, 8'h00, 4'hF, 0, 0, 1'b0, "pat_top");
        run_op(2'd2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, "pat_zero");
        run_op(2'd3, 8'h55, 8'h66, 8'h77, 4'h1, 0, 0, 1'b0, "cmd3");
        run_op(2'd1, 8'd20, 8'h00, 8'd5, 4'h0, 0, 0, 1'b0, "div_20_5");
        run_op(2'd1, 8'd20, 8'h00, 8'd5, 4'h0, 3, 3, 1'b1, "div_20_5_stall");

        // Asynchronous reset in the middle of a long divide.
        @(negedge CLK);
        CMD = 2'd1; OPA = 8'd255; OPC = 8'd1; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (20) @(negedge CLK);
        check("midrun_busy", 32'(BUSY), 32'd1);
        #2 RESET = 1'b1;
        #1 check_reset_outputs("async_reset");
        last_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) last_req = 1'b1;
        end
        check("reset_no_done", 32'(last_req), 32'd0);
        RESET = 1'b0;
        run_op(2'd1, 8'd100, 8'h00, 8'd7, 4'h0, 0, 0, 1'b0, "post_reset_div");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iter_ctrl.md
# alu_iter_ctrl

Multi-cycle sequencer for the shared combinational ALU. It runs iterative operations that the single-cycle ALU cannot complete in one pass: normalize (shift left until MSB set), divide by repeated subtraction, and 4-bit pattern count over a 16-bit window. It sits beside the main datapath and borrows the ALU one cycle at a time through a request/grant handshake with the datapath's ALU input mux.

## Interface
No parameters; all widths are fixed at 8-bit data, 4-bit pattern and 3-bit ALU opcode.
- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  launch command; sampled only in IDLE
- CMD  in  2  0=NORM, 1=DIV, 2=PATCNT, 3=reserved
- OPA  in  8  operand A (NORM value, DIV dividend, PATCNT window high byte)
- OPB  in  8  PATCNT window low byte
- OPC  in  8  DIV divisor
- PAT  in  4  PATCNT pattern
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  error/degenerate flag, valid with DONE, held after
- RESULT  out  8  primary result, held until next START
- COUNT  out  8  secondary result, held until next START
- ALU_REQ  out  1  requests the shared ALU
- ALU_GNT  in  1  datapath grants the ALU for this cycle
- ALU_OP  out  3  opcode to ALU (definitions package constants)
- ALU_A, ALU_B  out  8  ALU data inputs
- ALU_CI  out  1  ALU carry-in, always 0
- ALU_OUT  in  8  ALU result
- ALU_CO  in  1  ALU carry/borrow out

## Operation
- States: IDLE, RUN, FIN.
- IDLE to RUN: on START=1. OPA/OPB/OPC/PAT/CMD are captured into internal registers. RESULT, COUNT and ERR are cleared.
- RUN to FIN: on the terminating step.
- FIN to IDLE: unconditional.
- START outside IDLE: ignored.
- NORM (ALU_OP=kSLL, ALU_A=R):
  - R=OPA, n=0.
  - Each granted RUN cycle: if R[7]=1, terminate with RESULT=R, COUNT=n. Otherwise R<=ALU_OUT and n<=n+1.
  - OPA=0: terminate in the first RUN cycle with RESULT=0, COUNT=0, ERR=1. No shift is performed.
- DIV (ALU_OP=kSUB, ALU_A=R, ALU_B=D):
  - R=OPA, D=OPC, Q=0.
  - Each granted RUN cycle: if ALU_CO=0 (no borrow), R<=ALU_OUT and Q<=Q+1. If ALU_CO=1, terminate with RESULT=Q, COUNT=R.
  - OPC=0: terminate in the first RUN cycle, without ALU_REQ, with RESULT=8'hFF, COUNT=OPA, ERR=1.
- PATCNT (no ALU use):
  - W={OPA,OPB}; offset k runs 0..12 over W[k+3:k], one offset per RUN cycle.
  - COUNT = number of matches with PAT (0..13).
  - RESULT = lowest matching offset, or 8'hFF if there is no match.
  - Terminates after offset 12.
- CMD=3: terminate in the first RUN cycle with ERR=1, RESULT=0, COUNT=0.
- ALU_REQ=1 only in RUN with CMD NORM or DIV, and not on the OPC=0 path.
- Stall rule: a RUN cycle with ALU_REQ=1 and ALU_GNT=0 changes no state.
- When not requesting: ALU_OP=kADD, ALU_A=0, ALU_B=0.

## Timing
- ALU is combinational. ALU_OUT and ALU_CO are consumed in the same cycle that ALU_A/B/OP are driven, and registered at the next edge.
- Launch: START high at edge 0; RUN begins at cycle 1.
- Number of RUN cycles, assuming continuous grant:
  - NORM: shifts+1.
  - DIV: Q+1.
  - PATCNT: 13.
  - Degenerate cases: 1.
  - Each cycle with ALU_GNT=0 adds one cycle.
- DONE=1 for exactly the single FIN cycle. RESULT, COUNT and ERR are valid in that cycle and held afterward.
- BUSY=1 in RUN and FIN, 0 in IDLE. A new START is accepted in the cycle after FIN.
- Worst case: DIV with OPA=255, OPC=1 takes 256 RUN cycles. Q never wraps.
- Reset, asynchronous, at any time including mid-command:
  - state=IDLE.
  - BUSY, DONE, ERR, ALU_REQ = 0.
  - RESULT, COUNT = 0.
  - ALU_OP=kADD, ALU_A=0, ALU_B=0, ALU_CI=0.
  - No DONE is issued for the aborted command.

## Test plan
- NORM, OPA=8'h01, GNT tied 1 → 8 RUN cycles, DONE on cycle 9, RESULT=8'h80, COUNT=7, ERR=0. NORM, OPA=0 → RESULT=0, COUNT=0, ERR=1, DONE on cycle 2.
- DIV, OPA=100, OPC=7 → RESULT=14, COUNT=2, DONE on cycle 16. DIV, OPC=0 → RESULT=8'hFF, COUNT=OPA, ERR=1, ALU_REQ never asserted.
- DIV, OPA=255, OPC=1 → RESULT=255, COUNT=0, 256 RUN cycles, no wrap.
- PATCNT, OPA=8'hAA, OPB=8'hAA, PAT=4'hA → COUNT=7, RESULT=0. PAT=4'hF → COUNT=0, RESULT=8'hFF.
- DIV, OPA=20, OPC=5, ALU_GNT low for 3 cycles mid-run → RESULT=4, COUNT=0, DONE 3 cycles later than the no-stall run. START pulsed while BUSY → ignored.
- RESET asserted asynchronously mid-DIV → all outputs return to reset values immediately, no DONE. Next START runs normally.
